// File: rtl/hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// It keeps a shadow copy of the ID/EX, EX/MEM and MEM/WB destination,
// RegWrite and MemRead fields. From that copy it drives the two EX-stage
// ALU-operand forwarding selects. It also produces the load-use stall and
// the taken-branch flush controls, and counts stalls and flushes for
// performance debug.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   id_*                fields of the instruction currently in ID
//   ex_branch_taken     branch resolved taken in EX this cycle
//   forward_a/b         ALU operand mux selects
//                       0 = ID/EX value, 1 = MEM/WB writeback, 2 = EX/MEM ALU
//   pc_write            PC register write enable
//   ifid_write          IF/ID register write enable
//   idex_bubble         zero the control fields loaded into ID/EX this edge
//   ifid_flush          load a NOP into IF/ID this edge
//   stall_count         saturating count of load-use stall cycles
//   flush_count         saturating count of taken-branch flushes
// ---------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_branch_taken,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  ifid_flush,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_WB   = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Shadow pipeline state.
    logic                  ex_v, ex_regwrite, ex_memread;
    logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_dest;
    logic                  mem_v, mem_regwrite;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  wb_v, wb_regwrite;
    logic [REG_ADDR_W-1:0] wb_dest;

    // A "writer" produces a value somebody may consume; $0 never counts.
    logic ex_writer, mem_writer, wb_writer;
    assign ex_writer  = ex_v  && ex_regwrite  && (ex_dest  != '0);
    assign mem_writer = mem_v && mem_regwrite && (mem_dest != '0);
    assign wb_writer  = wb_v  && wb_regwrite  && (wb_dest  != '0);

    // MEM is checked first so the newest producer wins.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
        if (mem_writer && (mem_dest == src))
            return FWD_MEM;
        else if (wb_writer && (wb_dest == src))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

    always_comb begin
        forward_a = FWD_NONE;
        forward_b = FWD_NONE;
        if (ex_v) begin
            forward_a = fwd_sel(ex_rs);
            forward_b = fwd_sel(ex_rt);
        end
    end

    // Load-use: the load's data is not available until it leaves MEM.
    logic load_use, branch, stall;
    assign load_use = id_valid && ex_writer && ex_memread &&
                      ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

    // Reset forces default outputs immediately even if a branch is asserted.
    // A taken branch discards the stalled instruction, so it overrides the
    // stall and the stall is not counted.
    assign branch = ex_branch_taken && !reset;
    assign stall  = load_use && !branch && !reset;

    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = stall || branch;
    assign ifid_flush  = branch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_v         <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_dest      <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_v        <= 1'b0;
            mem_dest     <= '0;
            mem_regwrite <= 1'b0;
            wb_v         <= 1'b0;
            wb_dest      <= '0;
            wb_regwrite  <= 1'b0;
        end else begin
            wb_v         <= mem_v;
            wb_dest      <= mem_dest;
            wb_regwrite  <= mem_regwrite;
            mem_v        <= ex_v;
            mem_dest     <= ex_dest;
            mem_regwrite <= ex_regwrite;
            ex_v         <= id_valid && !idex_bubble;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_dest      <= id_dest;
            ex_regwrite  <= id_regwrite;
            ex_memread   <= id_memread;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != CNT_MAX))
                stall_count <= stall_count + CNT_W'(1);
            if (branch && (flush_count != CNT_MAX))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
